div_shift_sub: RTL and testbench

Sequential restoring shift-subtract divider: the inverse operation of the team's shift-add multiplier datapath.
- Takes a WIDTH-bit dividend and divisor on a start pulse.
- Performs one trial subtraction per clock.
- Presents the quotient and remainder with a one-cycle Done strobe.
- Sits in the RISC execute stage beside the multiplier; the ALU issues DIV/REM through it.

---
 rtl/div_pkg.sv | 17 +
 rtl/div_ctrl.sv | 74 +++++++
 rtl/div_shift_sub.sv | 155 +++++++++++++++
 tb/tb_div_shift_sub.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the shift-subtract divider.
// Signed operation is enabled by defining SIGNED_DIV_EN.
package div_pkg;

    localparam int DIV_WIDTH = 16;
    localparam int DIV_CNT_W = 5;

    // Quotient reported on divide-by-zero, sliced to WIDTH by users.
    localparam logic [63:0] DIV0_QUOT = '1;

    // Controller states, kept as plain constants for legacy tooling.
    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

endpackage

// File: rtl/div_ctrl.sv
// Divider controller: IDLE/RUN/DONE sequencing and iteration count.
// Drives load, step, fixup and done strobes for the datapath.
module div_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic Clk,
    input  logic rst,
    input  logic st,
    input  logic div_zero,
    output logic load,
    output logic load_zero,
    output logic step,
    output logic fixup,
    output logic done,
    output logic busy
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next-state and counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (st) begin
                    cnt_d   = '0;
                    state_d = div_zero ? DONE : RUN;
                end
            end
            RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Control strobes decoded from the current state.
    always_comb begin
        load      = (state_q == IDLE) && st && !div_zero;
        load_zero = (state_q == IDLE) && st && div_zero;
        step      = (state_q == RUN);
        fixup     = (state_q == RUN) && (cnt_q == LAST);
        done      = (state_q == DONE);
        busy      = (state_q == RUN) || (state_q == DONE);
    end

    // State and counter registers.
    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/div_shift_sub.sv
// Restoring shift-subtract divider, one trial subtraction per clock.
// Define SIGNED_DIV_EN for two's-complement operands.
module div_shift_sub
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic             Clk,
    input  logic             rst,
    input  logic             St,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic [WIDTH-1:0] Quociente,
    output logic [WIDTH-1:0] Resto,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero
);

    logic load, load_zero, step, fixup;
    logic div_zero;

    logic [WIDTH:0]   r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             dz_q, dz_d;

    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;

    assign div_zero = (Divisor == '0);

    div_ctrl #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_ctrl (
        .Clk       (Clk),
        .rst       (rst),
        .st        (St),
        .div_zero  (div_zero),
        .load      (load),
        .load_zero (load_zero),
        .step      (step),
        .fixup     (fixup),
        .done      (Done),
        .busy      (Busy)
    );

`ifdef SIGNED_DIV_EN
    logic a_neg_q, a_neg_d;
    logic b_neg_q, b_neg_d;

    // Operand magnitudes; the most-negative value maps onto itself,
    // which is correct when read as unsigned.
    always_comb begin
        a_in = Dividend[WIDTH-1] ? ('0 - Dividend) : Dividend;
        b_in = Divisor[WIDTH-1]  ? ('0 - Divisor)  : Divisor;
    end

    // Operand sign registers used by the final fix-up.
    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            a_neg_q <= 1'b0;
            b_neg_q <= 1'b0;
        end else begin
            a_neg_q <= a_neg_d;
            b_neg_q <= b_neg_d;
        end
    end
`else
    // Unsigned build passes operands through untouched.
    always_comb begin
        a_in = Dividend;
        b_in = Divisor;
    end
`endif

    // Shift {R,Q} left and trial-subtract the divisor.
    always_comb begin
        r_shift = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
        trial   = r_shift - {1'b0, d_q};
    end

    // Datapath next-state: load, iterate, fix up.
    always_comb begin
        r_d  = r_q;
        q_d  = q_q;
        d_d  = d_q;
        dz_d = dz_q;
`ifdef SIGNED_DIV_EN
        a_neg_d = a_neg_q;
        b_neg_d = b_neg_q;
`endif
        if (load) begin
            d_d  = b_in;
            q_d  = a_in;
            r_d  = '0;
            dz_d = 1'b0;
`ifdef SIGNED_DIV_EN
            a_neg_d = Dividend[WIDTH-1];
            b_neg_d = Divisor[WIDTH-1];
`endif
        end else if (load_zero) begin
            q_d  = DIV0_QUOT[WIDTH-1:0];
            r_d  = {1'b0, Dividend};
            dz_d = 1'b1;
        end else if (step) begin
            if (!trial[WIDTH]) begin
                r_d = trial;
                q_d = {q_q[WIDTH-2:0], 1'b1};
            end else begin
                r_d = r_shift;
                q_d = {q_q[WIDTH-2:0], 1'b0};
            end
`ifdef SIGNED_DIV_EN
            if (fixup) begin
                if (a_neg_q != b_neg_q) begin
                    q_d = '0 - q_d;
                end
                if (a_neg_q) begin
                    r_d = {1'b0, ('0 - r_d[WIDTH-1:0])};
                end
            end
`endif
        end
    end

`ifndef SIGNED_DIV_EN
    logic unused_fixup;
    assign unused_fixup = fixup;
`endif

    // Datapath registers.
    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            r_q  <= '0;
            q_q  <= '0;
            d_q  <= '0;
            dz_q <= 1'b0;
        end else begin
            r_q  <= r_d;
            q_q  <= q_d;
            d_q  <= d_d;
            dz_q <= dz_d;
        end
    end

    assign Quociente = q_q;
    assign Resto     = r_q[WIDTH-1:0];
    assign DivZero   = dz_q;

endmodule

// File: tb/tb_div_shift_sub.sv
// Self-checking bench for div_shift_sub: directed cases plus random
// operands against an arithmetic reference model.
module tb_div_shift_sub;

    logic        Clk = 1'b0;
    logic        rst = 1'b1;
    logic        St = 1'b0;
    logic [15:0] Dividend = '0;
    logic [15:0] Divisor = '0;
    logic [15:0] Quociente;
    logic [15:0] Resto;
    logic        Busy;
    logic        Done;
    logic        DivZero;

    int n_chk = 0;
    int n_pass = 0;

    div_shift_sub dut (
        .Clk       (Clk),
        .rst       (rst),
        .St        (St),
        .Dividend  (Dividend),
        .Divisor   (Divisor),
        .Quociente (Quociente),
        .Resto     (Resto),
        .Busy      (Busy),
        .Done      (Done),
        .DivZero   (DivZero)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic void model(input logic [15:0] a,
                                  input logic [15:0] b,
                                  output logic [15:0] q,
                                  output logic [15:0] r,
                                  output logic dz);
        int sa, sb, qq, rr;
        if (b == 16'h0) begin
            q  = 16'hFFFF;
            r  = a;
            dz = 1'b1;
        end else begin
`ifdef SIGNED_DIV_EN
            sa = int'($signed(a));
            sb = int'($signed(b));
`else
            sa = int'({16'h0, a});
            sb = int'({16'h0, b});
`endif
            qq = sa / sb;
            rr = sa % sb;
            q  = qq[15:0];
            r  = rr[15:0];
            dz = 1'b0;
        end
    endfunction

    // Runs one division; optional St pulses (with junk operands)
    // are injected after edge p1/p2 of the run.
    task automatic do_op(input string tag, input logic [15:0] a,
                         input logic [15:0] b, input int p1,
                         input int p2);
        logic [15:0] eq, er;
        logic        edz;
        int          n;
        int          lat;
        bit          busy_ok;
        model(a, b, eq, er, edz);
        lat = edz ? 1 : 17;
        @(negedge Clk);
        Dividend = a;
        Divisor  = b;
        St       = 1'b1;
        @(posedge Clk);
        #1;
        St       = 1'b0;
        Dividend = 16'($urandom);
        Divisor  = 16'($urandom);
        n        = 1;
        busy_ok  = 1'b1;
        while (!Done && n < 40) begin
            if (!Busy) busy_ok = 1'b0;
            if (n == p1 || n == p2) St = 1'b1;
            @(posedge Clk);
            #1;
            St = 1'b0;
            n++;
        end
        chk({tag, " latency"}, 32'(n), 32'(lat));
        chk({tag, " busy"}, {31'h0, busy_ok & Busy}, 32'h1);
        chk({tag, " quot"}, {16'h0, Quociente}, {16'h0, eq});
        chk({tag, " rem"}, {16'h0, Resto}, {16'h0, er});
        chk({tag, " dz"}, {31'h0, DivZero}, {31'h0, edz});
        @(posedge Clk);
        #1;
        chk({tag, " done1"}, {30'h0, Done, Busy}, 32'h0);
        chk({tag, " hold"}, {Quociente, Resto}, {eq, er});
    endtask

    initial begin
        logic [15:0] ra, rb;
        #12;
        chk("reset", {Quociente, Resto}, 32'h0);
        chk("reset flags", {29'h0, Busy, Done, DivZero}, 32'h0);
        @(negedge Clk);
        rst = 1'b0;

        do_op("100/7", 16'd100, 16'd7, -1, -1);
        do_op("ffff/1", 16'hFFFF, 16'd1, -1, -1);
        do_op("5/9", 16'd5, 16'd9, -1, -1);
        do_op("1234/0", 16'd1234, 16'd0, -1, -1);
        do_op("8/2", 16'd8, 16'd2, -1, -1);
        do_op("ign st", 16'd100, 16'd7, 3, 16);
        do_op("8/2b", 16'd8, 16'd2, -1, -1);
`ifdef SIGNED_DIV_EN
        do_op("-100/7", 16'hFF9C, 16'h0007, -1, -1);
        do_op("min/-1", 16'h8000, 16'hFFFF, -1, -1);
`endif

        // Asynchronous abort in the middle of a run.
        @(negedge Clk);
        Dividend = 16'd100;
        Divisor  = 16'd7;
        St       = 1'b1;
        @(posedge Clk);
        #1;
        St = 1'b0;
        repeat (7) @(posedge Clk);
        #3;
        chk("pre-rst busy", {31'h0, Busy}, 32'h1);
        rst = 1'b1;
        #1;
        chk("async rst q/r", {Quociente, Resto}, 32'h0);
        chk("async rst flg", {29'h0, Busy, Done, DivZero}, 32'h0);
        @(negedge Clk);
        rst = 1'b0;
        do_op("after rst", 16'd100, 16'd7, -1, -1);

        // St held high: second op starts straight after DONE.
        @(negedge Clk);
        Dividend = 16'd50;
        Divisor  = 16'd0;
        St       = 1'b1;
        @(posedge Clk);
        #1;
        chk("held dz done", {31'h0, Done}, 32'h1);
        Divisor = 16'd3;
        @(posedge Clk);
        #1;
        chk("held idle", {31'h0, Busy}, 32'h0);
        @(posedge Clk);
        #1;
        St = 1'b0;
        chk("held restart", {31'h0, Busy}, 32'h1);
        repeat (16) @(posedge Clk);
        #1;
        chk("held done", {31'h0, Done}, 32'h1);
        chk("held result", {Quociente, Resto}, {16'd16, 16'd2});
        @(posedge Clk);

        for (int i = 0; i < 60; i++) begin
            ra = 16'($urandom);
            case ($urandom_range(0, 5))
                0:       rb = 16'h0;
                1:       rb = 16'($urandom_range(1, 15));
                2:       rb = 16'hFFFF;
                default: rb = 16'($urandom);
            endcase
            do_op("rand", ra, rb, -1, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got hang expected finish");
        $fatal(1);
    end

endmodule
